alu_result_stage: RTL and testbench

- Registered, handshaked capture stage directly downstream of the combinational shift ALU (`sll_ALU`).
- Accepts the ALU result word and its overflow/carry/equal flags under valid/ready.
- Buffers up to two results in a 2-entry FIFO and presents them to the writeback consumer, adding a derived zero flag and a saturating overflow-event counter.
- Decouples the ALU's combinational path from writeback timing.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_res_fifo2.sv | 60 ++++++
 rtl/alu_result_stage.sv | 119 +++++++++++
 tb/tb_alu_result_stage.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ============================================================================
// alu_pkg : shared types and constants for the ALU result capture stage
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam int ALU_W      = 32;
  localparam int FIFO_DEPTH = 2;

  typedef struct packed {
    logic [ALU_W-1:0] s;
    logic             of;
    logic             cary;
    logic             eq;
    logic             zero;
  } alu_res_t;

endpackage

`default_nettype wire

// File: rtl/alu_res_fifo2.sv
// ============================================================================
// alu_res_fifo2 : 2-entry FIFO of ALU result records, head driven from storage
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module alu_res_fifo2
  import alu_pkg::*;
#(
  parameter type T = alu_res_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_push,
  input  logic i_pop,
  input  T     i_data,
  output T     o_head,
  output logic o_full,
  output logic o_empty
);

  localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1);

  T                   r_mem [FIFO_DEPTH];
  logic               r_wr_ptr;
  logic               r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;

  assign o_full  = (r_count == c_cnt_w'(FIFO_DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (i_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      // A simultaneous push and pop leaves the occupancy unchanged.
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_result_stage.sv
// ============================================================================
// alu_result_stage : registered valid/ready capture of sll_ALU results with
// zero flag and saturating overflow counter. Option: ALU_RESULT_STICKY_EN.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module alu_result_stage
  import alu_pkg::*;
#(
  parameter int W     = ALU_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_s,
  input  logic             in_of,
  input  logic             in_cary,
  input  logic             in_eq,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_s,
  output logic             out_of,
  output logic             out_cary,
  output logic             out_eq,
  output logic             out_zero,
  output logic [CNT_W-1:0] ovf_cnt,
`ifdef ALU_RESULT_STICKY_EN
  output logic             sticky_of,
  output logic             sticky_cary,
`endif
  input  logic             clr_cnt
);

  typedef struct packed {
    logic [W-1:0] s;
    logic         of;
    logic         cary;
    logic         eq;
    logic         zero;
  } res_t;

  res_t             w_in;
  res_t             w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [CNT_W-1:0] r_ovf_cnt;

  // Ready depends only on registered occupancy, never on out_ready.
  assign in_ready  = ~w_full;
  assign out_valid = ~w_empty;
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  assign w_in.s    = in_s;
  assign w_in.of   = in_of;
  assign w_in.cary = in_cary;
  assign w_in.eq   = in_eq;
  assign w_in.zero = (in_s == '0);

  alu_res_fifo2 #(
    .T (res_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_in),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign out_s    = w_head.s;
  assign out_of   = w_head.of;
  assign out_cary = w_head.cary;
  assign out_eq   = w_head.eq;
  assign out_zero = w_head.zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_cnt <= '0;
    end else if (clr_cnt) begin
      r_ovf_cnt <= '0;
    end else if (w_push && in_of && (r_ovf_cnt != '1)) begin
      r_ovf_cnt <= r_ovf_cnt + 1'b1;
    end
  end

  assign ovf_cnt = r_ovf_cnt;

`ifdef ALU_RESULT_STICKY_EN
  logic r_sticky_of;
  logic r_sticky_cary;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky_of   <= 1'b0;
      r_sticky_cary <= 1'b0;
    end else if (clr_cnt) begin
      r_sticky_of   <= 1'b0;
      r_sticky_cary <= 1'b0;
    end else if (w_push) begin
      r_sticky_of   <= r_sticky_of   | in_of;
      r_sticky_cary <= r_sticky_cary | in_cary;
    end
  end

  assign sticky_of   = r_sticky_of;
  assign sticky_cary = r_sticky_cary;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_result_stage.sv
// ============================================================================
// tb_alu_result_stage : directed stimulus with queue scoreboard and monitor
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_alu_result_stage;

  typedef struct packed {
    logic [31:0] s;
    logic        of;
    logic        cary;
    logic        eq;
    logic        zero;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_s;
  logic        in_of;
  logic        in_cary;
  logic        in_eq;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_s;
  logic        out_of;
  logic        out_cary;
  logic        out_eq;
  logic        out_zero;
  logic [15:0] ovf_cnt;
  logic        clr_cnt;

  logic        s_in_ready;
  logic        s_out_valid;
  logic [31:0] s_out_s;
  logic        s_out_of;
  logic        s_out_cary;
  logic        s_out_eq;
  logic        s_out_zero;
  logic [1:0]  s_ovf_cnt;
`ifdef ALU_RESULT_STICKY_EN
  logic        sticky_of;
  logic        sticky_cary;
  logic        s_sticky_of;
  logic        s_sticky_cary;
`endif

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  alu_result_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_s       (in_s),
    .in_of      (in_of),
    .in_cary    (in_cary),
    .in_eq      (in_eq),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_s      (out_s),
    .out_of     (out_of),
    .out_cary   (out_cary),
    .out_eq     (out_eq),
    .out_zero   (out_zero),
    .ovf_cnt    (ovf_cnt),
`ifdef ALU_RESULT_STICKY_EN
    .sticky_of  (sticky_of),
    .sticky_cary(sticky_cary),
`endif
    .clr_cnt    (clr_cnt)
  );

  // Narrow-counter instance shares the stimulus to exercise saturation.
  alu_result_stage #(.W(32), .CNT_W(2)) dut_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (s_in_ready),
    .in_s       (in_s),
    .in_of      (in_of),
    .in_cary    (in_cary),
    .in_eq      (in_eq),
    .out_valid  (s_out_valid),
    .out_ready  (out_ready),
    .out_s      (s_out_s),
    .out_of     (s_out_of),
    .out_cary   (s_out_cary),
    .out_eq     (s_out_eq),
    .out_zero   (s_out_zero),
    .ovf_cnt    (s_ovf_cnt),
`ifdef ALU_RESULT_STICKY_EN
    .sticky_of  (s_sticky_of),
    .sticky_cary(s_sticky_cary),
`endif
    .clr_cnt    (clr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [31:0] s, input logic of, input logic cary, input logic eq);
    int waited = 0;
    in_valid = 1'b1;
    in_s     = s;
    in_of    = of;
    in_cary  = cary;
    in_eq    = eq;
    while (!in_ready && waited < 50) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 50 cycles");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    sb.push_back('{s: s, of: of, cary: cary, eq: eq, zero: (s == 32'h0)});
    #1;
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_out: got s=%0h with empty scoreboard expected nothing", out_s);
      end else begin
        exp_t e;
        exp_t a;
        e = sb.pop_front();
        a = '{s: out_s, of: out_of, cary: out_cary, eq: out_eq, zero: out_zero};
        if (a !== e) begin
          n_bad++;
          $display("FAIL out_entry: got s=%0h of=%0b c=%0b eq=%0b z=%0b expected s=%0h of=%0b c=%0b eq=%0b z=%0b",
                   a.s, a.of, a.cary, a.eq, a.zero, e.s, e.of, e.cary, e.eq, e.zero);
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_s      = '0;
    in_of     = 1'b0;
    in_cary   = 1'b0;
    in_eq     = 1'b0;
    out_ready = 1'b0;
    clr_cnt   = 1'b0;

    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready",  in_ready,  1);
    check("rst_out_s",     out_s,     0);
    check("rst_out_zero",  out_zero,  0);
    check("rst_ovf_cnt",   ovf_cnt,   0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single transfer
    out_ready = 1'b1;
    send(32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0);
    check("t1_out_valid", out_valid, 1);
    check("t1_out_s",     out_s,     32'hFFFF_FFFE);
    check("t1_out_cary",  out_cary,  1);
    check("t1_out_zero",  out_zero,  0);
    check("t1_ovf_cnt",   ovf_cnt,   0);
    idle(2);

    // Back-pressure fill then drain
    out_ready = 1'b0;
    send(32'h0000_0001, 1'b0, 1'b0, 1'b0);
    send(32'h0000_0000, 1'b0, 1'b0, 1'b0);
    check("t2_in_ready_full", in_ready, 0);
    check("t2_out_s",         out_s,    1);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check("t2_hold_valid", out_valid, 1);
      check("t2_hold_s",     out_s,     1);
      check("t2_hold_ready", in_ready,  0);
    end
    out_ready = 1'b1;
    idle(3);
    check("t2_drained", out_valid, 0);

    // Streaming: simultaneous push and pop at count 1
    for (int i = 0; i < 11; i++) begin
      send(32'h100 + i, 1'b0, 1'b0, i[0]);
      check("t3_in_ready", in_ready,  1);
      check("t3_valid",    out_valid, 1);
    end
    idle(2);
    check("t3_drained", out_valid, 0);

    // Overflow counting and clear-over-increment
    for (int i = 0; i < 5; i++) begin
      send(32'hAAAA_AAA8, 1'b1, 1'b0, 1'b0);
    end
    check("t4_ovf_cnt5", ovf_cnt,   5);
    check("t4_sat_cnt",  s_ovf_cnt, 3);
`ifdef ALU_RESULT_STICKY_EN
    check("t4_sticky_of_set",   sticky_of,   1);
    check("t4_sticky_cary_set", sticky_cary, 1);
`endif
    in_valid = 1'b1;
    in_s     = 32'hAAAA_AAA8;
    in_of    = 1'b1;
    in_cary  = 1'b0;
    in_eq    = 1'b0;
    clr_cnt  = 1'b1;
    check("t4_clr_ready", in_ready, 1);
    @(posedge clk);
    sb.push_back('{s: 32'hAAAA_AAA8, of: 1'b1, cary: 1'b0, eq: 1'b0, zero: 1'b0});
    #1;
    in_valid = 1'b0;
    clr_cnt  = 1'b0;
    check("t4_ovf_cleared", ovf_cnt,   0);
    check("t4_sat_cleared", s_ovf_cnt, 0);
`ifdef ALU_RESULT_STICKY_EN
    check("t4_sticky_of_clr",   sticky_of,   0);
    check("t4_sticky_cary_clr", sticky_cary, 0);
`endif
    idle(2);

    // Reset mid-operation with the FIFO full
    out_ready = 1'b0;
    send(32'h0000_0005, 1'b1, 1'b0, 1'b0);
    send(32'h0000_0006, 1'b0, 1'b1, 1'b0);
    check("t5_full",      in_ready,  0);
    check("t5_ovf_cnt",   ovf_cnt,   1);
    check("t5_out_valid", out_valid, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_ovf",   ovf_cnt,   0);
    check("t5_rst_ready", in_ready,  1);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(32'h0000_1234, 1'b0, 1'b0, 1'b1);
    check("t5_post_valid", out_valid, 1);
    check("t5_post_s",     out_s,     32'h1234);
    idle(1);
    check("t5_alone", out_valid, 0);

    idle(2);
    check("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
